// File: rtl/secded_pipeline.sv
// Pipelined Hamming SECDED codec with error injection, valid/ready handshake and
// saturating counters for corrected and uncorrectable words.
module secded_pipeline #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8,
   localparam int PAR_A = $clog2(DATA_W + 1),
   localparam int PAR_B = $clog2(DATA_W + PAR_A + 1),
   localparam int PAR_W = $clog2(DATA_W + PAR_B + 1),
   localparam int CW    = DATA_W + PAR_W + 1
) (
   input  logic              reloj,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] dato_entrada,
   input  logic [CW-1:0]     dato_error,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] corregido,
   output logic [CW-1:0]     palabra_corregida,
   output logic [PAR_W-1:0]  sindrome,
   output logic              error_simple,
   output logic              error_doble,
   input  logic              clr_contadores,
   output logic [CNT_W-1:0]  cnt_simple,
   output logic [CNT_W-1:0]  cnt_doble
);

   function automatic bit is_check_pos(int pos);
      return (pos & (pos - 1)) == 0;
   endfunction

   function automatic int data_pos(int k);
      int cnt;
      cnt = 0;
      for (int i = 1; i < CW; i++) begin
         if (!is_check_pos(i)) begin
            if (cnt == k) return i;
            cnt++;
         end
      end
      return 0;
   endfunction

   function automatic int data_idx(int pos);
      int cnt;
      cnt = 0;
      for (int i = 1; i < pos; i++) begin
         if (!is_check_pos(i)) cnt++;
      end
      return cnt;
   endfunction

   // Hamming positions covered by check bit 2**j; bit 0 is never included.
   function automatic logic [CW-1:0] check_mask(int j);
      logic [CW-1:0] m;
      m = '0;
      for (int i = 1; i < CW; i++) begin
         if (((i >> j) & 1) == 1) m = m | (CW'(1) << i);
      end
      return m;
   endfunction

   logic              adv;
   logic [CW-1:0]     placed;
   logic [CW-1:0]     enc_body;
   logic [CW-1:0]     encoded;

   logic              v1;
   logic [CW-1:0]     rx1;
   logic [PAR_W-1:0]  syn_c;
   logic              par_c;

   logic              v2;
   logic [CW-1:0]     rx2;
   logic [PAR_W-1:0]  syn2;
   logic              p2;

   logic [CW-1:0]     flip;
   logic              single_c;
   logic              double_c;
   logic [CW-1:0]     fixed_word;
   logic [DATA_W-1:0] fixed_data;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar i = 0; i < CW; i++) begin : g_place
      if (i != 0 && !is_check_pos(i)) begin : g_data
         assign placed[i] = dato_entrada[data_idx(i)];
      end else begin : g_zero
         assign placed[i] = 1'b0;
      end
   end

   for (genvar i = 0; i < CW; i++) begin : g_enc
      if (i != 0 && is_check_pos(i)) begin : g_chk
         assign enc_body[i] = ^(placed & check_mask($clog2(i)));
      end else begin : g_pass
         assign enc_body[i] = placed[i];
      end
   end

   assign encoded = {enc_body[CW-1:1], ^enc_body};

   for (genvar j = 0; j < PAR_W; j++) begin : g_syn
      assign syn_c[j] = ^(rx1 & check_mask(j));
   end

   assign par_c = ^rx1;

   // A syndrome of zero with odd parity points at bit 0, so one shift covers both single cases.
   always_comb begin
      flip     = '0;
      single_c = 1'b0;
      double_c = 1'b0;
      if (p2) begin
         if (int'(syn2) < CW) begin
            single_c = 1'b1;
            flip     = CW'(1) << syn2;
         end else begin
            double_c = 1'b1;
         end
      end else if (syn2 != '0) begin
         double_c = 1'b1;
      end
   end

   assign fixed_word = rx2 ^ flip;

   for (genvar k = 0; k < DATA_W; k++) begin : g_extract
      assign fixed_data[k] = fixed_word[data_pos(k)];
   end

   // All three stages move together; a stalled output freezes the whole pipe, bubbles included.
   always_ff @(posedge reloj) begin
      if (reset) begin
         v1                <= 1'b0;
         rx1               <= '0;
         v2                <= 1'b0;
         rx2               <= '0;
         syn2              <= '0;
         p2                <= 1'b0;
         out_valid         <= 1'b0;
         corregido         <= '0;
         palabra_corregida <= '0;
         sindrome          <= '0;
         error_simple      <= 1'b0;
         error_doble       <= 1'b0;
      end else if (adv) begin
         v1                <= in_valid;
         rx1               <= encoded ^ dato_error;
         v2                <= v1;
         rx2               <= rx1;
         syn2              <= syn_c;
         p2                <= par_c;
         out_valid         <= v2;
         corregido         <= fixed_data;
         palabra_corregida <= fixed_word;
         sindrome          <= syn2;
         error_simple      <= v2 && single_c;
         error_doble       <= v2 && double_c;
      end
   end

   // Statistics count delivered words only; a clear beats an increment in the same cycle.
   always_ff @(posedge reloj) begin
      if (reset || clr_contadores) begin
         cnt_simple <= '0;
         cnt_doble  <= '0;
      end else if (out_valid && out_ready) begin
         if (error_simple && cnt_simple != '1) cnt_simple <= cnt_simple + 1'b1;
         if (error_doble && cnt_doble != '1) cnt_doble <= cnt_doble + 1'b1;
      end
   end

endmodule
